fifod2udp_tx: RTL and testbench

Transmit-side bridge between the outbound data FIFO (fifod, read side) and the MAC UDP transmit payload port.
- On an fs/fd job handshake it latches a byte count and raises a send request to the MAC.
- It waits for the MAC's prepare flag, then streams exactly that many bytes from fifod into udp_txd/udp_txen.
- It sits in the gmii_txc domain, directly downstream of fifod and upstream of mac.

---
 rtl/fifod2udp_tx.sv | 146 ++++++++++++++
 tb/tb_fifod2udp_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifod2udp_tx.sv
// Transmit bridge from the fifod read port to the MAC UDP payload port.
// Latches a job length, requests a UDP frame, then streams exactly that many bytes.
module fifod2udp_tx #(
  parameter int unsigned LEN_W   = 12,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fs,
  output logic             fd,
  output logic             err,
  input  logic [LEN_W-1:0] data_len,
  output logic             fifod_rxen,
  input  logic [7:0]       fifod_rxd,
  input  logic             fifod_empty,
  output logic             flag_udp_tx_req,
  input  logic             flag_udp_tx_prep,
  output logic             udp_txen,
  output logic [7:0]       udp_txd,
  output logic [3:0]       so
);

  typedef enum logic [3:0] {
    IDLE  = 4'h1,
    REQ   = 4'h2,
    READ  = 4'h3,
    FLUSH = 4'h4,
    DONE  = 4'h5,
    ERR   = 4'h6
  } state_t;

  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  state_t           state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      tmo;
  logic             uflow;
  // Set once fs has been seen low, so a held-high fs cannot start a second job.
  logic             armed;

  assign so = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      len_r           <= '0;
      cnt             <= '0;
      tmo             <= '0;
      uflow           <= 1'b0;
      armed           <= 1'b0;
      fd              <= 1'b0;
      err             <= 1'b0;
      fifod_rxen      <= 1'b0;
      flag_udp_tx_req <= 1'b0;
      udp_txen        <= 1'b0;
      udp_txd         <= 8'h00;
    end else begin
      // Payload path: one register stage behind the read enable.
      udp_txen <= fifod_rxen;
      if (fifod_rxen) begin
        udp_txd <= fifod_rxd;
      end
      if (fifod_rxen && fifod_empty) begin
        uflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!fs) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            len_r <= data_len;
            cnt   <= '0;
            tmo   <= '0;
            uflow <= 1'b0;
            if (data_len == '0) begin
              state <= DONE;
              fd    <= 1'b1;
              err   <= 1'b0;
            end else begin
              state           <= REQ;
              flag_udp_tx_req <= 1'b1;
            end
          end
        end

        REQ: begin
          // A prep arriving on the timeout cycle still wins.
          if (flag_udp_tx_prep) begin
            state           <= READ;
            flag_udp_tx_req <= 1'b0;
            fifod_rxen      <= 1'b1;
            cnt             <= '0;
          end else if (tmo == TMO_LAST) begin
            state           <= ERR;
            flag_udp_tx_req <= 1'b0;
            fd              <= 1'b1;
            err             <= 1'b1;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        READ: begin
          if (cnt == LEN_W'(len_r - 1'b1)) begin
            state      <= FLUSH;
            fifod_rxen <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FLUSH: begin
          fd <= 1'b1;
          if (uflow) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state <= DONE;
            err   <= 1'b0;
          end
        end

        DONE, ERR: begin
          if (!fs) begin
            state <= IDLE;
            fd    <= 1'b0;
            err   <= 1'b0;
            armed <= 1'b1;
          end
        end

        default: begin
          state           <= IDLE;
          fd              <= 1'b0;
          err             <= 1'b0;
          fifod_rxen      <= 1'b0;
          flag_udp_tx_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifod2udp_tx.sv
// Bench for fifod2udp_tx: show-ahead fifod model, byte scoreboard and per-cycle protocol checker.
module tb_fifod2udp_tx;

  localparam int unsigned LEN_W = 12;
  localparam logic [15:0] TMO   = 16'd16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fs;
  logic             fd;
  logic             err;
  logic [LEN_W-1:0] data_len;
  logic             fifod_rxen;
  logic [7:0]       fifod_rxd;
  logic             fifod_empty;
  logic             req;
  logic             prep;
  logic             udp_txen;
  logic [7:0]       udp_txd;
  logic [3:0]       so;

  int checks = 0;
  int errors = 0;

  // fifod model: data visible while non-empty, pointer advances on each read.
  logic [7:0]  fmem [0:8191];
  int unsigned frd = 0;
  int unsigned fwr = 0;
  assign fifod_empty = (frd == fwr);
  assign fifod_rxd   = fifod_empty ? 8'hEE : fmem[frd[12:0]];
  always @(posedge clk) if (fifod_rxen && !fifod_empty) frd <= frd + 1;

  // Reference model: contents of fifod in order, and bytes still owed to the MAC.
  logic [7:0] mdl_q[$];
  logic [7:0] exp_q[$];
  int txen_total = 0, req_total = 0, rxen_total = 0;
  int txen_base = 0, req_base = 0, rxen_base = 0;
  int cur_len = 0;

  always #5 clk = ~clk;

  fifod2udp_tx #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .err(err), .data_len(data_len),
    .fifod_rxen(fifod_rxen), .fifod_rxd(fifod_rxd), .fifod_empty(fifod_empty),
    .flag_udp_tx_req(req), .flag_udp_tx_prep(prep),
    .udp_txen(udp_txen), .udp_txd(udp_txd), .so(so)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fifo(input logic [7:0] b);
    fmem[fwr[12:0]] = b;
    fwr = fwr + 1;
    mdl_q.push_back(b);
  endtask

  task automatic fifo_flush();
    fwr = frd;
    mdl_q.delete();
  endtask

  // A job of n bytes owes n fifod bytes; reads past the end return the empty pattern.
  task automatic expect_frame(input int n);
    for (int i = 0; i < n; i++) begin
      if (mdl_q.size() > 0) exp_q.push_back(mdl_q.pop_front());
      else exp_q.push_back(8'hEE);
    end
  endtask

  task automatic start_job(input int n);
    txen_base = txen_total;
    req_base  = req_total;
    rxen_base = rxen_total;
    cur_len   = n;
    data_len  = LEN_W'(n);
    fs        = 1'b1;
  endtask

  task automatic prep_pulse();
    expect_frame(cur_len);
    prep = 1'b1;
    step(1);
    prep = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (fd !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    chk("fd_wait", 32'(fd), 1);
  endtask

  // Per-cycle protocol and payload checker.
  task automatic monitor();
    logic       p_rxen;
    logic       p_rst;
    logic [7:0] e;
    p_rxen = 1'b0;
    p_rst  = 1'b0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        chk("rst_outputs", 32'({fd, err, fifod_rxen, req, udp_txen}), 0);
        chk("rst_txd", 32'(udp_txd), 0);
        chk("rst_so", 32'(so), 32'h1);
      end else begin
        chk("txen_align", 32'(udp_txen), 32'(p_rxen));
        if (udp_txen) begin
          if (exp_q.size() == 0) begin
            chk("txd_extra", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("txd", 32'(udp_txd), 32'(e));
          end
        end
        if (err) chk("err_implies_fd", 32'(fd), 1);
        if (so == 4'h6) chk("err_quiet", 32'({fifod_rxen, req, udp_txen}), 0);
        if (fifod_rxen) chk("rxen_without_req", 32'(req), 0);
      end
      txen_total += int'(udp_txen);
      req_total  += int'(req);
      rxen_total += int'(fifod_rxen);
      p_rxen = fifod_rxen;
      p_rst  = rst_n;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    fs       = 1'b0;
    prep     = 1'b0;
    data_len = '0;
    fork
      monitor();
    join_none
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("idle_so", 32'(so), 32'h1);

    // 1: four-byte job, prep three cycles into the request
    push_fifo(8'hA0); push_fifo(8'hA1); push_fifo(8'hA2); push_fifo(8'hA3);
    start_job(4);
    step(1);
    chk("t1_req", 32'(req), 1);
    chk("t1_so_req", 32'(so), 32'h2);
    data_len = 12'd9;
    step(2);
    prep_pulse();
    chk("t1_req_drop", 32'(req), 0);
    chk("t1_rxen_first", 32'(fifod_rxen), 1);
    chk("t1_txen_not_yet", 32'(udp_txen), 0);
    step(1);
    chk("t1_txen_first", 32'(udp_txen), 1);
    chk("t1_txd_first", 32'(udp_txd), 32'hA0);
    wait_done(20);
    chk("t1_txen_count", 32'(txen_total - txen_base), 4);
    chk("t1_rxen_count", 32'(rxen_total - rxen_base), 4);
    chk("t1_err", 32'(err), 0);
    chk("t1_so_done", 32'(so), 32'h5);
    fs = 1'b0;
    chk("t1_fd_hold", 32'(fd), 1);
    step(1);
    chk("t1_fd_drop", 32'(fd), 0);
    chk("t1_so_idle", 32'(so), 32'h1);

    // 2: zero-length job completes with no request and no reads
    start_job(0);
    step(1);
    chk("t2_fd", 32'(fd), 1);
    chk("t2_so_done", 32'(so), 32'h5);
    step(2);
    chk("t2_err", 32'(err), 0);
    chk("t2_no_req", 32'(req_total - req_base), 0);
    chk("t2_no_rxen", 32'(rxen_total - rxen_base), 0);
    fs = 1'b0;
    step(1);
    chk("t2_so_idle", 32'(so), 32'h1);

    // 3: MAC never prepares; request times out after 16 cycles
    start_job(5);
    step(1);
    chk("t3_req", 32'(req), 1);
    wait_done(40);
    chk("t3_req_cycles", 32'(req_total - req_base), 16);
    chk("t3_err", 32'(err), 1);
    chk("t3_so_err", 32'(so), 32'h6);
    chk("t3_no_txen", 32'(txen_total - txen_base), 0);
    fs = 1'b0;
    step(1);
    chk("t3_err_clear", 32'(err), 0);

    // 4: underflow on the third read keeps the frame length but flags an error
    push_fifo(8'hB0); push_fifo(8'hB1);
    start_job(3);
    step(2);
    prep_pulse();
    wait_done(20);
    chk("t4_txen_count", 32'(txen_total - txen_base), 3);
    chk("t4_err", 32'(err), 1);
    chk("t4_so_err", 32'(so), 32'h6);
    fs = 1'b0;
    step(1);

    // 5: reset in the middle of an eight-byte job, then a clean two-byte job
    for (int i = 0; i < 8; i++) push_fifo(8'hC0 + 8'(i));
    start_job(8);
    step(1);
    prep_pulse();
    for (int i = 0; i < 20 && (txen_total - txen_base) < 3; i++) step(1);
    rst_n = 1'b0;
    step(1);
    chk("t5_rst_outputs", 32'({fd, err, fifod_rxen, req, udp_txen}), 0);
    chk("t5_rst_so", 32'(so), 32'h1);
    rst_n = 1'b1;
    exp_q.delete();
    fifo_flush();
    step(3);
    chk("t5_no_retrigger", 32'(so), 32'h1);
    fs = 1'b0;
    step(1);
    push_fifo(8'hD0); push_fifo(8'hD1);
    start_job(2);
    step(1);
    chk("t5_so_req", 32'(so), 32'h2);
    prep_pulse();
    wait_done(20);
    chk("t5_txen_count", 32'(txen_total - txen_base), 2);
    chk("t5_err", 32'(err), 0);
    fs = 1'b0;
    step(1);

    // 6: maximum-length job followed by a one-byte job
    for (int i = 0; i < 4095; i++) push_fifo(8'(i * 7 + 3));
    start_job(4095);
    step(1);
    prep_pulse();
    wait_done(4200);
    chk("t6_txen_count", 32'(txen_total - txen_base), 4095);
    chk("t6_rxen_count", 32'(rxen_total - rxen_base), 4095);
    chk("t6_err", 32'(err), 0);
    data_len = 12'd1;
    step(3);
    chk("t6_hold_done", 32'(so), 32'h5);
    fs = 1'b0;
    step(1);
    chk("t6_so_idle", 32'(so), 32'h1);
    push_fifo(8'hF1);
    start_job(1);
    step(1);
    chk("t6b_so_req", 32'(so), 32'h2);
    prep_pulse();
    wait_done(20);
    chk("t6b_txen_count", 32'(txen_total - txen_base), 1);
    chk("t6b_err", 32'(err), 0);
    fs = 1'b0;
    step(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
